// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
//   SEG_PAT     : hex nibble -> {1'b1, g,f,e,d,c,b,a}, active-low
//   SEG_OFF     : segment bus with every segment dark
//   SEG_DP_ONLY : segment bus with only the decimal point lit
//   AN_OFF      : all anodes off
//   NDIG        : number of digits on the display
package seg7_pkg;

    localparam int unsigned NDIG = 4;

    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [7:0] SEG_DP_ONLY = 8'h7F;
    localparam logic [3:0] AN_OFF      = 4'hF;

    // Active-low patterns, bit 7 (dp) held high; the dp is applied separately.
    localparam logic [7:0] SEG_PAT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // One buffer entry: the hex value plus its decimal points.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
    } seg7_buf_t;

    // Phase within a digit slot.
    typedef enum logic {
        PhBlank,
        PhOn
    } seg7_phase_t;

endpackage

// File: rtl/seg7_pattern.sv
// Hex nibble to active-low gfedcba segment pattern.
//   nib_i : hex digit value
//   seg_o : {g,f,e,d,c,b,a}, active-low
module seg7_pattern
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_PAT[nib_i][6:0];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// A pending buffer takes LOAD strobes; it is committed to the display buffer only on the
// frame boundary (or continuously while scanning is disabled), so a frame never mixes values.
//   clk_i   : system clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : scan enable
//   data_i  : hex value, digit k = data_i[4k+3:4k], digit 0 rightmost
//   dp_i    : decimal points, dp_i[k] lights digit k
//   load_i  : single-cycle strobe capturing data_i/dp_i into the pending buffer
//   zsup_i  : leading-zero suppression enable (live)
//   pend_o  : pending buffer holds data not yet displayed
//   frame_o : one-cycle pulse in the commit cycle
//   nseg_o  : {dp,g,f,e,d,c,b,a}, active-low, registered
//   nan_o   : digit anodes, active-low, registered
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    input  logic        zsup_i,
    output logic        pend_o,
    output logic        frame_o,
    output logic [7:0]  nseg_o,
    output logic [3:0]  nan_o
);

    localparam logic [15:0] DIV_MAX   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);

    logic [15:0] div_q, div_d;
    logic [1:0]  dig_q, dig_d;
    logic        pend_q, pend_d;
    seg7_buf_t   pbuf_q, pbuf_d;
    seg7_buf_t   disp_q, disp_d;
    logic [7:0]  nseg_q, nseg_d;
    logic [3:0]  nan_q, nan_d;

    logic            frame;
    seg7_phase_t     phase;
    logic [3:0]      nib;
    logic            dp_bit;
    logic [6:0]      seg;
    logic [NDIG-1:0] lead_zero;
    logic            suppress;
    logic [3:0]      an_sel;

    assign frame   = en_i && (dig_q == 2'd3) && (div_q == DIV_MAX);
    assign frame_o = frame;
    assign pend_o  = pend_q;
    assign nseg_o  = nseg_q;
    assign nan_o   = nan_q;

    // Scan counters; disabling parks the scan at the start of digit 0.
    always_comb begin
        div_d = div_q;
        dig_d = dig_q;
        if (!en_i) begin
            div_d = '0;
            dig_d = '0;
        end else if (div_q == DIV_MAX) begin
            div_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Double buffer. A LOAD landing in the commit cycle bypasses straight to the display.
    always_comb begin
        pbuf_d = pbuf_q;
        disp_d = disp_q;
        pend_d = pend_q;
        if (load_i) begin
            pbuf_d = '{data: data_i, dp: dp_i};
            if (frame) begin
                disp_d = '{data: data_i, dp: dp_i};
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (pend_q && (frame || !en_i)) begin
            disp_d = pbuf_q;
            pend_d = 1'b0;
        end
    end

    assign phase  = (div_q < BLANK_END) ? PhBlank : PhOn;
    assign nib    = disp_q.data[dig_q*4 +: 4];
    assign dp_bit = disp_q.dp[dig_q];
    assign an_sel = ~(4'b0001 << dig_q);

    seg7_pattern u_pattern (
        .nib_i (nib),
        .seg_o (seg)
    );

    // lead_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        lead_zero[3] = (disp_q.data[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_q.data[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_q.data[7:4] == 4'h0);
        lead_zero[0] = lead_zero[1] && (disp_q.data[3:0] == 4'h0);
    end

    assign suppress = zsup_i && (dig_q != 2'd0) && lead_zero[dig_q];

    always_comb begin
        nseg_d = SEG_OFF;
        nan_d  = AN_OFF;
        if (en_i && (phase == PhOn)) begin
            if (suppress) begin
                // A suppressed digit still shows its decimal point.
                if (dp_bit) begin
                    nan_d  = an_sel;
                    nseg_d = SEG_DP_ONLY;
                end
            end else begin
                nan_d  = an_sel;
                nseg_d = {~dp_bit, seg};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            dig_q  <= '0;
            pend_q <= 1'b0;
            pbuf_q <= '0;
            disp_q <= '0;
            nseg_q <= SEG_OFF;
            nan_q  <= AN_OFF;
        end else begin
            div_q  <= div_d;
            dig_q  <= dig_d;
            pend_q <= pend_d;
            pbuf_q <= pbuf_d;
            disp_q <= disp_d;
            nseg_q <= nseg_d;
            nan_q  <= nan_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        zsup;
    logic        pend;
    logic        frame;
    logic [7:0]  nseg;
    logic [3:0]  nan;

    int checks = 0;
    int errors = 0;

    // Reference model: t counts enabled cycles since the scan last restarted.
    int          t;
    logic [15:0] md_data, mp_data;
    logic [3:0]  md_dp, mp_dp;
    logic        mpend;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .data_i  (data),
        .dp_i    (dp),
        .load_i  (load),
        .zsup_i  (zsup),
        .pend_o  (pend),
        .frame_o (frame),
        .nseg_o  (nseg),
        .nan_o   (nan)
    );

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hD8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        md_data = '0; md_dp = '0;
        mp_data = '0; mp_dp = '0;
        mpend = 1'b0;
    endtask

    function automatic logic m_frame();
        return en && ((t % FR) == FR - 1);
    endfunction

    // One clock: check combinational outputs, predict registered outputs, advance.
    task automatic tick();
        logic [7:0] eseg;
        logic [3:0] ean;
        logic [3:0] nib;
        logic       dpb;
        logic       f;
        int         pos;
        int         dg;
        #1;
        f = m_frame();
        chk("frame", {31'd0, frame}, {31'd0, f});
        chk("pend", {31'd0, pend}, {31'd0, mpend});
        pos  = t % SD;
        dg   = (t / SD) % 4;
        eseg = 8'hFF;
        ean  = 4'hF;
        if (en && pos >= BC) begin
            nib = 4'(md_data >> (4 * dg));
            dpb = md_dp[dg];
            if (zsup && dg != 0 && (md_data >> (4 * dg)) == 16'd0) begin
                if (dpb) begin
                    ean  = 4'hF ^ (4'b0001 << dg);
                    eseg = 8'h7F;
                end
            end else begin
                ean  = 4'hF ^ (4'b0001 << dg);
                eseg = (seg_of(nib) & 8'h7F) | (dpb ? 8'h00 : 8'h80);
            end
        end
        if (load) begin
            mp_data = data;
            mp_dp   = dp;
            if (f) begin
                md_data = data;
                md_dp   = dp;
                mpend   = 1'b0;
            end else begin
                mpend = 1'b1;
            end
        end else if (mpend && (f || !en)) begin
            md_data = mp_data;
            md_dp   = mp_dp;
            mpend   = 1'b0;
        end
        t = en ? t + 1 : 0;
        @(posedge clk);
        #1;
        chk("nseg", {24'd0, nseg}, {24'd0, eseg});
        chk("nan", {28'd0, nan}, {28'd0, ean});
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next cycle is the commit cycle.
    task automatic run_to_frame();
        for (int i = 0; i < FR + 1; i++) begin
            if (m_frame()) return;
            tick();
        end
        chk("frame_reached", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_nseg", {24'd0, nseg}, 32'hFF);
        chk("rst_nan", {28'd0, nan}, 32'hF);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_nan", {28'd0, nan}, 32'hF);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rd;
        rst_n = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        zsup  = 1'b0;
        data  = '0;
        dp    = '0;
        model_reset();
        #1;
        do_reset();

        // Load 1234, let it commit, then watch two full frames.
        en = 1'b1;
        do_load(16'h1234, 4'h0);
        run_to_frame();
        tick();
        run(3);
        chk("spot_d0_nan", {28'd0, nan}, 32'hE);
        chk("spot_d0_nseg", {24'd0, nseg}, 32'h99);
        run(SD);
        chk("spot_d1_nan", {28'd0, nan}, 32'hD);
        chk("spot_d1_nseg", {24'd0, nseg}, 32'hB0);
        run(2 * FR);

        // Mid-frame LOAD: current frame keeps old digits.
        run_to_frame();
        run(2 * SD + 3);
        do_load(16'hABCD, 4'h0);
        run(2 * FR);

        // LOAD in the commit cycle bypasses the pending stage.
        run_to_frame();
        do_load(16'h00F0, 4'h0);
        run(FR + 4);

        // Leading-zero suppression with a lit dp on a suppressed digit.
        zsup = 1'b1;
        do_load(16'h0005, 4'b0100);
        run(2 * FR + 2);
        zsup = 1'b0;
        run(FR);

        // Disable mid-slot, load while disabled, re-enable.
        run(SD + 4);
        en = 1'b0;
        tick();
        chk("dis_nan", {28'd0, nan}, 32'hF);
        do_load(16'h9876, 4'b1001);
        run(3);
        en = 1'b1;
        run(FR + 5);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                rd   = 16'($urandom);
                rd   = rd >> (4 * $urandom_range(0, 4));
                data = rd;
                dp   = 4'($urandom);
                load = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0) zsup = ~zsup;
            tick();
        end

        // Reset during an ON phase; display returns to zero.
        en   = 1'b1;
        zsup = 1'b0;
        do_load(16'h4321, 4'h0);
        run_to_frame();
        tick();
        run(BC + 2);
        do_reset();
        run(3);
        chk("post_rst_nan", {28'd0, nan}, 32'hE);
        chk("post_rst_nseg", {24'd0, nseg}, 32'hC0);
        run(FR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
